// File: rtl/sd_drive_arbiter_if.sv
// Bus bundle between the floppy drives, the arbiter and hps_io sector transfer.
interface sd_drive_arbiter_if #(
  parameter int unsigned NBDRIV = 4,
  parameter int unsigned LBA_W  = 32,
  parameter int unsigned BUF_AW = 9
);
  // drive side
  logic [NBDRIV*LBA_W-1:0] drv_lba;
  logic [NBDRIV-1:0]       drv_rd;
  logic [NBDRIV-1:0]       drv_wr;
  logic [NBDRIV-1:0]       drv_done;
  logic [NBDRIV-1:0]       drv_err;
  logic [BUF_AW-1:0]       drv_buff_addr;
  logic [7:0]              drv_buff_dout;
  logic [NBDRIV-1:0]       drv_buff_wr;
  logic [NBDRIV*8-1:0]     drv_buff_din;
  // hps_io side
  logic [NBDRIV*LBA_W-1:0] sd_lba;
  logic [NBDRIV-1:0]       sd_rd;
  logic [NBDRIV-1:0]       sd_wr;
  logic [NBDRIV-1:0]       sd_ack;
  logic [BUF_AW-1:0]       sd_buff_addr;
  logic [7:0]              sd_buff_dout;
  logic                    sd_buff_wr;
  logic [NBDRIV*8-1:0]     sd_buff_din;
  logic [NBDRIV-1:0]       img_mounted;

  // arbiter view
  modport slave (
    input  drv_lba, drv_rd, drv_wr, drv_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, img_mounted,
    output drv_done, drv_err, drv_buff_addr, drv_buff_dout, drv_buff_wr,
    output sd_lba, sd_rd, sd_wr, sd_buff_din
  );

  // drives + hps_io view
  modport master (
    output drv_lba, drv_rd, drv_wr, drv_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, img_mounted,
    input  drv_done, drv_err, drv_buff_addr, drv_buff_dout, drv_buff_wr,
    input  sd_lba, sd_rd, sd_wr, sd_buff_din
  );
endinterface

// File: rtl/sd_drive_arbiter.sv
// Round-robin arbiter giving NBDRIV virtual drives serialized access to the
// hps_io sector interface, with per-transfer LBA latch, timeout and remount abort.
module sd_drive_arbiter #(
  parameter int unsigned NBDRIV  = 4,
  parameter int unsigned LBA_W   = 32,
  parameter int unsigned BUF_AW  = 9,
  parameter int unsigned TIMEOUT = 32'd16777216
) (
  input logic clk_sys,
  input logic reset,
  sd_drive_arbiter_if.slave bus
);

  localparam int unsigned GW = (NBDRIV > 1) ? $clog2(NBDRIV) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_RELEASE} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           g_q, g_d;
  logic [GW-1:0]           rr_q, rr_d;
  logic [LBA_W-1:0]        lba_q, lba_d;
  logic                    wr_op_q, wr_op_d;
  logic                    abort_q, abort_d;
  logic                    fired_q, fired_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NBDRIV-1:0]       sd_rd_q, sd_rd_d;
  logic [NBDRIV-1:0]       sd_wr_q, sd_wr_d;
  logic [NBDRIV-1:0]       done_q, done_d;
  logic [NBDRIV-1:0]       err_q, err_d;
  logic [NBDRIV*LBA_W-1:0] sd_lba_q, sd_lba_d;

  logic [NBDRIV-1:0]       pending;
  logic [NBDRIV-1:0]       g_onehot;
  logic                    ack_g, mount_g, req_g;
  logic                    rq_active, timeout_hit;
  logic                    found;
  logic [GW-1:0]           pick, idx;
  logic [LBA_W-1:0]        lba_pick;
  logic                    rd_pick;
  logic [NBDRIV*LBA_W-1:0] lba_placed;
  logic [GW-1:0]           rr_next;

  assign pending     = bus.drv_rd | bus.drv_wr;
  assign g_onehot    = NBDRIV'(1) << g_q;
  assign ack_g       = |(bus.sd_ack & g_onehot);
  assign mount_g     = |(bus.img_mounted & g_onehot);
  assign req_g       = |(pending & g_onehot);
  assign rq_active   = |(sd_rd_q | sd_wr_q);
  assign timeout_hit = rq_active && (cnt_q == CNT_LAST);
  assign rr_next     = GW'((int'(g_q) + 1) % int'(NBDRIV));

  // First pending drive at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < int'(NBDRIV); i++) begin
      idx = GW'((int'(rr_q) + i) % int'(NBDRIV));
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Slice muxes: LBA/op of the candidate, latched LBA placed in the granted slot.
  always_comb begin
    lba_pick   = '0;
    rd_pick    = 1'b0;
    lba_placed = '0;
    for (int i = 0; i < int'(NBDRIV); i++) begin
      if (GW'(i) == pick) begin
        lba_pick = bus.drv_lba[i*LBA_W +: LBA_W];
        rd_pick  = bus.drv_rd[i];
      end
      if (GW'(i) == g_q) begin
        lba_placed[i*LBA_W +: LBA_W] = lba_q;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    rr_d     = rr_q;
    lba_d    = lba_q;
    wr_op_d  = wr_op_q;
    abort_d  = abort_q;
    fired_d  = fired_q;
    cnt_d    = cnt_q;
    sd_rd_d  = '0;
    sd_wr_d  = '0;
    done_d   = '0;
    err_d    = '0;
    sd_lba_d = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          g_d     = pick;
          lba_d   = lba_pick;
          wr_op_d = ~rd_pick;
          abort_d = 1'b0;
          fired_d = 1'b0;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        sd_lba_d = lba_placed;
        if (rq_active) cnt_d = cnt_q + CW'(1);
        if (mount_g || timeout_hit) begin
          abort_d = 1'b1;
          state_d = S_RELEASE;
        end else if (ack_g) begin
          state_d = S_XFER;
        end else begin
          sd_rd_d = wr_op_q ? '0 : g_onehot;
          sd_wr_d = wr_op_q ? g_onehot : '0;
        end
      end
      S_XFER: begin
        sd_lba_d = lba_placed;
        if (mount_g) begin
          abort_d = 1'b1;
          state_d = S_RELEASE;
        end else if (!ack_g) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Report once ack is gone, then hold until the drive drops its request.
        if (!fired_q) begin
          if (!ack_g) begin
            fired_d = 1'b1;
            done_d  = abort_q ? '0 : g_onehot;
            err_d   = abort_q ? g_onehot : '0;
            rr_d    = rr_next;
          end
        end else if (!req_g) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      g_q      <= '0;
      rr_q     <= '0;
      lba_q    <= '0;
      wr_op_q  <= 1'b0;
      abort_q  <= 1'b0;
      fired_q  <= 1'b0;
      cnt_q    <= '0;
      sd_rd_q  <= '0;
      sd_wr_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      sd_lba_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_q     <= rr_d;
      lba_q    <= lba_d;
      wr_op_q  <= wr_op_d;
      abort_q  <= abort_d;
      fired_q  <= fired_d;
      cnt_q    <= cnt_d;
      sd_rd_q  <= sd_rd_d;
      sd_wr_q  <= sd_wr_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sd_lba_q <= sd_lba_d;
    end
  end

  assign bus.sd_rd         = sd_rd_q;
  assign bus.sd_wr         = sd_wr_q;
  assign bus.sd_lba        = sd_lba_q;
  assign bus.drv_done      = done_q;
  assign bus.drv_err       = err_q;
  assign bus.drv_buff_addr = bus.sd_buff_addr;
  assign bus.drv_buff_dout = bus.sd_buff_dout;
  assign bus.sd_buff_din   = bus.drv_buff_din;
  assign bus.drv_buff_wr   = ((state_q == S_XFER) && bus.sd_buff_wr) ? g_onehot : '0;

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Bench for sd_drive_arbiter: drive/hps_io models plus an expected-grant queue.
module tb_sd_drive_arbiter;
  localparam int unsigned NBDRIV  = 4;
  localparam int unsigned LBA_W   = 32;
  localparam int unsigned BUF_AW  = 9;
  localparam int unsigned TIMEOUT = 16;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  sd_drive_arbiter_if #(.NBDRIV(NBDRIV), .LBA_W(LBA_W), .BUF_AW(BUF_AW)) bus ();

  sd_drive_arbiter #(.NBDRIV(NBDRIV), .LBA_W(LBA_W), .BUF_AW(BUF_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    int               drv;
    bit               wr;
    logic [LBA_W-1:0] lba;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   onehot_viol = 0;

  // More than one request line at once is never allowed.
  always @(negedge clk_sys)
    if (reset === 1'b0 && $countones(bus.sd_rd | bus.sd_wr) > 1) onehot_viol++;

  task automatic set_lba(input int i, input logic [LBA_W-1:0] v);
    bus.drv_lba[i*LBA_W +: LBA_W] = v;
  endtask

  // hps_io + drive model for one transfer; returns what it observed.
  task automatic host_xfer(input int ack_dly, input int nwr,
                           output int o_drv, output bit o_wr, output logic [LBA_W-1:0] o_lba,
                           output int o_lat, output int o_bwr, output int o_done,
                           output int o_err, output bit o_stray);
    logic [NBDRIV*LBA_W-1:0] rest;
    logic [NBDRIV-1:0]       oh;
    bit                      seen;
    o_drv = -1; o_wr = 1'b0; o_lba = '0; o_lat = 0; o_bwr = 0;
    o_done = 0; o_err = 0; o_stray = 1'b0; seen = 1'b0;
    while (!seen && o_lat < 40) begin
      @(negedge clk_sys);
      o_lat++;
      if ((bus.sd_rd | bus.sd_wr) != '0) seen = 1'b1;
    end
    if (!seen) return;
    for (int i = 0; i < int'(NBDRIV); i++)
      if (bus.sd_rd[i] | bus.sd_wr[i]) o_drv = i;
    o_wr  = bus.sd_wr[o_drv];
    o_lba = bus.sd_lba[o_drv*LBA_W +: LBA_W];
    rest  = bus.sd_lba;
    rest[o_drv*LBA_W +: LBA_W] = '0;
    if (rest != '0) o_stray = 1'b1;
    oh = NBDRIV'(1) << o_drv;
    for (int k = 1; k < ack_dly; k++) begin
      @(negedge clk_sys);
      if ((bus.sd_rd | bus.sd_wr) != oh) o_stray = 1'b1;
    end
    bus.sd_ack[o_drv] = 1'b1;
    @(negedge clk_sys);
    if ((bus.sd_rd | bus.sd_wr) != '0) o_stray = 1'b1;
    for (int b = 0; b < nwr; b++) begin
      bus.sd_buff_wr   = 1'b1;
      bus.sd_buff_addr = BUF_AW'(b);
      #1;
      if (bus.drv_buff_wr == oh) o_bwr++;
      else o_stray = 1'b1;
      @(negedge clk_sys);
    end
    bus.sd_buff_wr = 1'b0;
    #1;
    if (bus.drv_buff_wr != '0) o_stray = 1'b1;
    bus.sd_ack[o_drv] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_sys);
      if (bus.drv_done[o_drv] | bus.drv_err[o_drv]) begin
        if (bus.drv_done[o_drv]) o_done++;
        if (bus.drv_err[o_drv]) o_err++;
        bus.drv_rd[o_drv] = 1'b0;
        bus.drv_wr[o_drv] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.drv_lba = '0; bus.drv_rd = '0; bus.drv_wr = '0; bus.drv_buff_din = '0;
    bus.sd_ack = '0; bus.sd_buff_addr = '0; bus.sd_buff_dout = '0;
    bus.sd_buff_wr = 1'b1; bus.img_mounted = '0;
    repeat (3) @(negedge clk_sys);
    tests++; if ((bus.sd_rd | bus.sd_wr) !== '0) begin fails++; $display("FAIL reset_req: got %b expected 0", bus.sd_rd | bus.sd_wr); end
    tests++; if ((bus.drv_done | bus.drv_err) !== '0) begin fails++; $display("FAIL reset_pulses: got %b expected 0", bus.drv_done | bus.drv_err); end
    tests++; if (bus.drv_buff_wr !== '0) begin fails++; $display("FAIL reset_buff_wr: got %b expected 0", bus.drv_buff_wr); end
    tests++; if (bus.sd_lba !== '0) begin fails++; $display("FAIL reset_lba: got %h expected 0", bus.sd_lba); end
    bus.sd_buff_wr = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    tests++; if ((bus.sd_rd | bus.sd_wr) !== '0) begin fails++; $display("FAIL idle_req: got %b expected 0", bus.sd_rd | bus.sd_wr); end
    bus.drv_buff_din = 32'hA1B2_C3D4; bus.sd_buff_addr = 9'h1AB; bus.sd_buff_dout = 8'h5C;
    #1;
    tests++; if (bus.sd_buff_din !== 32'hA1B2_C3D4) begin fails++; $display("FAIL pass_din: got %h expected a1b2c3d4", bus.sd_buff_din); end
    tests++; if (bus.drv_buff_addr !== 9'h1AB) begin fails++; $display("FAIL pass_addr: got %h expected 1ab", bus.drv_buff_addr); end
    tests++; if (bus.drv_buff_dout !== 8'h5C) begin fails++; $display("FAIL pass_dout: got %h expected 5c", bus.drv_buff_dout); end
  endtask

  task automatic test_single_read();
    int drv, lat, bwr, dn, er; bit wr, stray; logic [LBA_W-1:0] lba; exp_t e;
    set_lba(0, 32'h123);
    bus.drv_rd = 4'b0001;
    exp_q.push_back('{drv: 0, wr: 1'b0, lba: 32'h123});
    host_xfer(5, 512, drv, wr, lba, lat, bwr, dn, er, stray);
    e = exp_q.pop_front();
    tests++; if (drv !== e.drv) begin fails++; $display("FAIL rd_drive: got %0d expected %0d", drv, e.drv); end
    tests++; if (wr !== e.wr) begin fails++; $display("FAIL rd_op: got %0d expected %0d", wr, e.wr); end
    tests++; if (lba !== e.lba) begin fails++; $display("FAIL rd_lba: got %h expected %h", lba, e.lba); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    tests++; if (bwr !== 512) begin fails++; $display("FAIL rd_buff_wr: got %0d expected 512", bwr); end
    tests++; if (dn !== 1 || er !== 0) begin fails++; $display("FAIL rd_done: got done=%0d err=%0d expected 1/0", dn, er); end
    tests++; if (stray !== 1'b0) begin fails++; $display("FAIL rd_stray: got %0d expected 0", stray); end
  endtask

  task automatic test_write_latch();
    int drv, lat, bwr, dn, er; bit wr, stray; logic [LBA_W-1:0] lba; exp_t e;
    bus.drv_buff_din[16 +: 8] = 8'hA5;
    set_lba(2, 32'hABC);
    bus.drv_wr = 4'b0100;
    exp_q.push_back('{drv: 2, wr: 1'b1, lba: 32'hABC});
    @(negedge clk_sys);
    set_lba(2, 32'hFFFF_0000);
    tests++; if (bus.sd_buff_din[16 +: 8] !== 8'hA5) begin fails++; $display("FAIL wr_din: got %h expected a5", bus.sd_buff_din[16 +: 8]); end
    host_xfer(3, 0, drv, wr, lba, lat, bwr, dn, er, stray);
    e = exp_q.pop_front();
    tests++; if (drv !== e.drv || wr !== e.wr) begin fails++; $display("FAIL wr_grant: got drv=%0d wr=%0d expected %0d/%0d", drv, wr, e.drv, e.wr); end
    tests++; if (lba !== e.lba) begin fails++; $display("FAIL wr_lba_latch: got %h expected %h", lba, e.lba); end
    tests++; if (bwr !== 0 || stray !== 1'b0) begin fails++; $display("FAIL wr_buff_wr: got %0d stray=%0d expected 0", bwr, stray); end
    tests++; if (dn !== 1 || er !== 0) begin fails++; $display("FAIL wr_done: got done=%0d err=%0d expected 1/0", dn, er); end
  endtask

  task automatic test_timeout();
    int n, hi, dn, er;
    set_lba(1, 32'h1111);
    bus.drv_rd = 4'b0010;
    n = 0;
    while (bus.sd_rd[1] !== 1'b1 && n < 20) begin @(negedge clk_sys); n++; end
    tests++; if (bus.sd_rd !== 4'b0010) begin fails++; $display("FAIL to_req: got %b expected 0010", bus.sd_rd); end
    hi = 0;
    while (bus.sd_rd[1] === 1'b1 && hi < 100) begin hi++; @(negedge clk_sys); end
    tests++; if (hi !== int'(TIMEOUT)) begin fails++; $display("FAIL to_duration: got %0d expected %0d", hi, TIMEOUT); end
    dn = 0; er = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_sys);
      dn += int'(bus.drv_done[1]);
      if (bus.drv_err[1]) begin er++; bus.drv_rd[1] = 1'b0; end
    end
    tests++; if (er !== 1 || dn !== 0) begin fails++; $display("FAIL to_err: got err=%0d done=%0d expected 1/0", er, dn); end
  endtask

  task automatic test_mount();
    int n, dn, er, early;
    set_lba(0, 32'h55);
    bus.drv_rd = 4'b0001;
    n = 0;
    while (bus.sd_rd[0] !== 1'b1 && n < 20) begin @(negedge clk_sys); n++; end
    tests++; if (bus.sd_rd !== 4'b0001) begin fails++; $display("FAIL mnt_req: got %b expected 0001", bus.sd_rd); end
    bus.sd_ack[0] = 1'b1;
    @(negedge clk_sys);
    bus.sd_buff_wr = 1'b1;
    bus.img_mounted[3] = 1'b1;
    @(negedge clk_sys);
    bus.img_mounted[3] = 1'b0;
    #1;
    tests++; if (bus.drv_buff_wr !== 4'b0001) begin fails++; $display("FAIL mnt_other: got %b expected 0001", bus.drv_buff_wr); end
    bus.img_mounted[0] = 1'b1;
    @(negedge clk_sys);
    bus.img_mounted[0] = 1'b0;
    #1;
    tests++; if (bus.drv_buff_wr !== 4'b0000 || bus.sd_rd !== 4'b0000) begin fails++; $display("FAIL mnt_abort: got buff_wr=%b sd_rd=%b expected 0/0", bus.drv_buff_wr, bus.sd_rd); end
    early = 0;
    repeat (3) begin @(negedge clk_sys); early += int'(bus.drv_err[0] | bus.drv_done[0]); end
    tests++; if (early !== 0) begin fails++; $display("FAIL mnt_wait_ack: got %0d pulses expected 0", early); end
    bus.sd_buff_wr = 1'b0;
    bus.sd_ack[0] = 1'b0;
    dn = 0; er = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_sys);
      dn += int'(bus.drv_done[0]);
      if (bus.drv_err[0]) begin er++; bus.drv_rd[0] = 1'b0; end
    end
    tests++; if (er !== 1 || dn !== 0) begin fails++; $display("FAIL mnt_err: got err=%0d done=%0d expected 1/0", er, dn); end
  endtask

  task automatic test_reset_mid_xfer();
    int n;
    set_lba(3, 32'h777);
    bus.drv_rd = 4'b1000;
    n = 0;
    while (bus.sd_rd[3] !== 1'b1 && n < 20) begin @(negedge clk_sys); n++; end
    bus.sd_ack[3] = 1'b1;
    @(negedge clk_sys);
    bus.sd_buff_wr = 1'b1;
    #1;
    tests++; if (bus.drv_buff_wr !== 4'b1000) begin fails++; $display("FAIL rst_pre_buff: got %b expected 1000", bus.drv_buff_wr); end
    tests++; if (bus.sd_lba[3*LBA_W +: LBA_W] !== 32'h777) begin fails++; $display("FAIL rst_pre_lba: got %h expected 777", bus.sd_lba[3*LBA_W +: LBA_W]); end
    #2 reset = 1'b1;
    #1;
    tests++; if (bus.drv_buff_wr !== '0 || bus.sd_lba !== '0) begin fails++; $display("FAIL rst_async: got buff_wr=%b lba=%h expected 0", bus.drv_buff_wr, bus.sd_lba); end
    tests++; if ((bus.sd_rd | bus.sd_wr | bus.drv_done | bus.drv_err) !== '0) begin fails++; $display("FAIL rst_async_ctl: got %b expected 0", bus.sd_rd | bus.sd_wr | bus.drv_done | bus.drv_err); end
    bus.drv_rd = '0; bus.drv_wr = '0; bus.sd_ack = '0; bus.sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  // Rounds 0/1: all four at once from rr=0. Round 2: drive 2 alone, then the
  // rest arrive mid-transfer (drive 3 with rd and wr both high) -> 2,3,0,1.
  task automatic test_back_to_back();
    int drv, lat, bwr, dn, er; bit wr, stray; logic [LBA_W-1:0] lba; exp_t e;
    for (int r = 0; r < 3; r++) begin
      if (r < 2) begin
        for (int i = 0; i < 4; i++) begin
          set_lba(i, 32'h1000 * (r + 1) + 32'(i));
          exp_q.push_back('{drv: i, wr: 1'b0, lba: 32'h1000 * (r + 1) + 32'(i)});
        end
        bus.drv_rd = 4'b1111;
      end else begin
        set_lba(2, 32'h2222);
        exp_q.push_back('{drv: 2, wr: 1'b0, lba: 32'h2222});
        bus.drv_rd = 4'b0100;
        @(negedge clk_sys);
        set_lba(3, 32'h3333); set_lba(0, 32'h3000); set_lba(1, 32'h3001);
        bus.drv_rd = 4'b1111;
        bus.drv_wr = 4'b1000;
        exp_q.push_back('{drv: 3, wr: 1'b0, lba: 32'h3333});
        exp_q.push_back('{drv: 0, wr: 1'b0, lba: 32'h3000});
        exp_q.push_back('{drv: 1, wr: 1'b0, lba: 32'h3001});
      end
      while (exp_q.size() > 0) begin
        host_xfer(3, 4, drv, wr, lba, lat, bwr, dn, er, stray);
        e = exp_q.pop_front();
        tests++; if (drv !== e.drv || wr !== e.wr) begin fails++; $display("FAIL b2b_order r%0d: got drv=%0d wr=%0d expected %0d/%0d", r, drv, wr, e.drv, e.wr); end
        tests++; if (lba !== e.lba) begin fails++; $display("FAIL b2b_lba r%0d: got %h expected %h", r, lba, e.lba); end
        tests++; if (dn !== 1 || er !== 0 || bwr !== 4 || stray !== 1'b0) begin fails++; $display("FAIL b2b_xfer r%0d drv%0d: got done=%0d err=%0d bwr=%0d stray=%0d expected 1/0/4/0", r, e.drv, dn, er, bwr, stray); end
      end
    end
  endtask

  task automatic test_onehot();
    tests++; if (onehot_viol !== 0) begin fails++; $display("FAIL onehot: got %0d violations expected 0", onehot_viol); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_latch();
    test_timeout();
    test_mount();
    test_reset_mid_xfer();
    test_back_to_back();
    test_onehot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1);
  end
endmodule
